// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to build the multi-cycle shift-add multiplier for alu_op 11; otherwise alu_op 11 is OR.
module ex_stage #(
  parameter int PC_WIDTH      = 12,
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic                     ex_alu_src,
  input  logic                     ex_branch,
  input  logic [1:0]               ex_alu_op,
  input  logic [PC_WIDTH-1:0]      ex_pc,
  input  logic [DATA_WIDTH-1:0]    ex_read_data1,
  input  logic [DATA_WIDTH-1:0]    ex_read_data2,
  input  logic [DATA_WIDTH-1:0]    ex_imm,
  input  logic [REGADDR_WIDTH-1:0] ex_rs,
  input  logic [REGADDR_WIDTH-1:0] ex_rt,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  input  logic                     mem_fwd_en,
  input  logic [REGADDR_WIDTH-1:0] mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0]    mem_fwd_data,
  input  logic                     wb_fwd_en,
  input  logic [REGADDR_WIDTH-1:0] wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0]    wb_fwd_data,
  output logic                     stall,
  output logic                     branch_taken,
  output logic [PC_WIDTH-1:0]      branch_target,
  output logic                     mem_reg_write,
  output logic                     mem_mem_read,
  output logic                     mem_mem_write,
  output logic [DATA_WIDTH-1:0]    mem_alu_result,
  output logic [DATA_WIDTH-1:0]    mem_store_data,
  output logic [REGADDR_WIDTH-1:0] mem_rd
);

  typedef struct packed {
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic [REGADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    store_data;
    logic [DATA_WIDTH-1:0]    alu_result;
  } exmem_t;

  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  exmem_t                exmem_d;
  exmem_t                exmem_q;

  // Register 0 is hard-wired zero, so a write to it must never be forwarded.
  always_comb begin
    fwd_a = ex_read_data1;
    if (mem_fwd_en && (mem_fwd_rd == ex_rs) && (mem_fwd_rd != '0))
      fwd_a = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_rd == ex_rs) && (wb_fwd_rd != '0))
      fwd_a = wb_fwd_data;

    fwd_b = ex_read_data2;
    if (mem_fwd_en && (mem_fwd_rd == ex_rt) && (mem_fwd_rd != '0))
      fwd_b = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_rd == ex_rt) && (wb_fwd_rd != '0))
      fwd_b = wb_fwd_data;
  end

  assign alu_b = ex_alu_src ? ex_imm : fwd_b;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mul_state_e;

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  mul_state_e            state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [DATA_WIDTH-1:0] acc_d, acc_q;
  logic [DATA_WIDTH-1:0] mcand_d, mcand_q;
  logic [DATA_WIDTH-1:0] mplier_d, mplier_q;
  logic                  mul_stall;

  // NOTE: every signal written here gets a default first, so no path through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mul_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if ((ex_alu_op == 2'b11) && !flush) begin
          state_d   = ST_BUSY;
          cnt_d     = '0;
          acc_d     = '0;
          mcand_d   = fwd_a;
          mplier_d  = alu_b;
          mul_stall = 1'b1;
        end
      end
      ST_BUSY: begin
        mul_stall = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          // Only the low DATA_WIDTH product bits are kept, so the partial sum can wrap.
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the multiplier datapath registers are reset too, so an aborted multiply leaves no stale operands behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // The IDLE-cycle stall depends on live inputs, so it is masked while reset is held.
  assign stall = mul_stall & ~reset;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    alu_result = '0;
    unique case (ex_alu_op)
      2'b00: alu_result = fwd_a + alu_b;
      2'b01: alu_result = fwd_a - alu_b;
      2'b10: alu_result = fwd_a & alu_b;
      2'b11: begin
`ifdef EX_MUL_EN
        // Only consumed in DONE, where the accumulator holds the finished product.
        alu_result = acc_q;
`else
        alu_result = fwd_a | alu_b;
`endif
      end
      default: alu_result = '0;
    endcase
  end

  assign branch_taken  = ex_branch & (fwd_a == fwd_b) & ~flush & ~stall;
  assign branch_target = ex_pc + ex_imm[PC_WIDTH-1:0];

  always_comb begin
    exmem_d = '0;
    if (!stall && !flush) begin
      exmem_d.reg_write  = ex_reg_write;
      exmem_d.mem_read   = ex_mem_read;
      exmem_d.mem_write  = ex_mem_write;
      exmem_d.rd         = ex_rd;
      exmem_d.store_data = fwd_b;
      exmem_d.alu_result = alu_result;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  assign mem_reg_write  = exmem_q.reg_write;
  assign mem_mem_read   = exmem_q.mem_read;
  assign mem_mem_write  = exmem_q.mem_write;
  assign mem_rd         = exmem_q.rd;
  assign mem_store_data = exmem_q.store_data;
  assign mem_alu_result = exmem_q.alu_result;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: randomized single-cycle traffic against an arithmetic
// reference model, directed corner cases, and the multiplier sequence when EX_MUL_EN is defined.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch;
  logic [1:0]  ex_alu_op;
  logic [11:0] ex_pc;
  logic [15:0] ex_read_data1, ex_read_data2, ex_imm;
  logic [2:0]  ex_rs, ex_rt, ex_rd;
  logic        mem_fwd_en;
  logic [2:0]  mem_fwd_rd;
  logic [15:0] mem_fwd_data;
  logic        wb_fwd_en;
  logic [2:0]  wb_fwd_rd;
  logic [15:0] wb_fwd_data;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic [15:0] mem_alu_result, mem_store_data;
  logic [2:0]  mem_rd;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .ex_pc(ex_pc), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All EX/MEM outputs packed: {reg_write, mem_read, mem_write, rd, store_data, alu_result}.
  wire [37:0] exmem_obs = {mem_reg_write, mem_mem_read, mem_mem_write, mem_rd, mem_store_data, mem_alu_result};

  // ---------------- reference model ----------------
  function automatic logic [15:0] operand_of(input logic [2:0] src, input logic [15:0] rf_val);
    if (mem_fwd_en && mem_fwd_rd != 3'd0 && mem_fwd_rd == src) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_rd != 3'd0 && wb_fwd_rd == src) return wb_fwd_data;
    return rf_val;
  endfunction

  function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    longint la = longint'(a);
    longint lb = longint'(b);
    case (op)
      2'd0: return 16'((la + lb) % 65536);
      2'd1: return 16'((la - lb + 65536) % 65536);
      2'd2: return a & b;
`ifdef EX_MUL_EN
      default: return 16'((la * lb) % 65536);
`else
      default: return a | b;
`endif
    endcase
  endfunction

  function automatic logic [37:0] exp_exmem();
    logic [15:0] a, b, opb;
    if (flush) return 38'd0;
    a   = operand_of(ex_rs, ex_read_data1);
    b   = operand_of(ex_rt, ex_read_data2);
    opb = ex_alu_src ? ex_imm : b;
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, b, alu_model(ex_alu_op, a, opb)};
  endfunction

  function automatic logic exp_taken();
    return ex_branch && !flush &&
           (operand_of(ex_rs, ex_read_data1) == operand_of(ex_rt, ex_read_data2));
  endfunction

  function automatic logic [11:0] exp_target();
    return 12'((int'(ex_pc) + int'(ex_imm % 4096)) % 4096);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    flush = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_alu_src = 0;
    ex_branch = 0; ex_alu_op = 2'd0; ex_pc = '0; ex_read_data1 = '0; ex_read_data2 = '0;
    ex_imm = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    mem_fwd_en = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_en = 0; wb_fwd_rd = '0; wb_fwd_data = '0;
  endtask

  task automatic rand_inputs(input bit allow_op3);
    flush         = ($urandom % 5) == 0;
    ex_reg_write  = 1'($urandom);
    ex_mem_read   = 1'($urandom);
    ex_mem_write  = 1'($urandom);
    ex_alu_src    = 1'($urandom);
    ex_branch     = 1'($urandom);
    ex_alu_op     = 2'($urandom);
    if (!allow_op3 && ex_alu_op == 2'd3) ex_alu_op = 2'($urandom % 3);
    ex_pc         = 12'($urandom);
    ex_read_data1 = 16'($urandom);
    ex_read_data2 = (($urandom % 3) == 0) ? ex_read_data1 : 16'($urandom);
    ex_imm        = 16'($urandom);
    ex_rs         = 3'($urandom);
    ex_rt         = 3'($urandom);
    ex_rd         = 3'($urandom);
    mem_fwd_en    = 1'($urandom);
    mem_fwd_rd    = 3'($urandom);
    mem_fwd_data  = 16'($urandom);
    wb_fwd_en     = 1'($urandom);
    wb_fwd_rd     = 3'($urandom);
    wb_fwd_data   = 16'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ex_reg_write = 1; ex_mem_read = 1; ex_alu_op = 2'd3; ex_read_data1 = 16'h1234; ex_rd = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exmem_obs !== 38'd0) begin
      errors++; $display("FAIL reset_exmem: got %h expected %h", exmem_obs, 38'd0);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    reset = 0;
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_alu_directed();
    logic [37:0] exp;
    clear_inputs();
    ex_reg_write = 1; ex_rd = 3'd2; ex_alu_op = 2'd0;
    ex_read_data1 = 16'h7FFF; ex_read_data2 = 16'h0001;
    exp = {1'b1, 2'b00, 3'd2, 16'h0001, 16'h8000};
    @(posedge clk); #1;
    checks++;
    if (exmem_obs !== exp) begin
      errors++; $display("FAIL add_7fff_plus_1: got %h expected %h", exmem_obs, exp);
    end
    ex_alu_op = 2'd1; ex_read_data1 = 16'h0000; ex_read_data2 = 16'h0001;
    @(posedge clk); #1;
    checks++;
    if (mem_alu_result !== 16'hFFFF) begin
      errors++; $display("FAIL sub_0_minus_1: got %h expected ffff", mem_alu_result);
    end
`ifndef EX_MUL_EN
    ex_alu_op = 2'd3; ex_read_data1 = 16'h00F0; ex_read_data2 = 16'h000F;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL or_stall: got %b expected 0", stall);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_alu_result !== 16'h00FF) begin
      errors++; $display("FAIL or_f0_0f: got %h expected 00ff", mem_alu_result);
    end
`endif
  endtask

  task automatic test_forwarding();
    clear_inputs();
    // AND with an all-ones immediate exposes operand A on the result.
    ex_alu_op = 2'd2; ex_alu_src = 1; ex_imm = 16'hFFFF;
    ex_rs = 3'd3; ex_rt = 3'd3; ex_read_data1 = 16'h0AAA; ex_read_data2 = 16'h0BBB;
    mem_fwd_en = 1; mem_fwd_rd = 3'd3; mem_fwd_data = 16'h0011;
    wb_fwd_en = 1; wb_fwd_rd = 3'd3; wb_fwd_data = 16'h0022;
    @(posedge clk); #1;
    checks++;
    if (mem_alu_result !== 16'h0011) begin
      errors++; $display("FAIL fwd_mem_priority: got %h expected 0011", mem_alu_result);
    end
    mem_fwd_rd = 3'd4;
    @(posedge clk); #1;
    checks++;
    if (mem_store_data !== 16'h0022) begin
      errors++; $display("FAIL fwd_wb_store: got %h expected 0022", mem_store_data);
    end
    ex_rs = 3'd0; mem_fwd_rd = 3'd0; wb_fwd_rd = 3'd0;
    @(posedge clk); #1;
    checks++;
    if (mem_alu_result !== 16'h0AAA) begin
      errors++; $display("FAIL fwd_r0_ignored: got %h expected 0aaa", mem_alu_result);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    ex_branch = 1; ex_read_data1 = 16'h0005; ex_read_data2 = 16'h0005;
    ex_pc = 12'h010; ex_imm = 16'hFFFC;
    #1;
    checks++;
    if ({branch_taken, branch_target} !== {1'b1, 12'h00C}) begin
      errors++; $display("FAIL beq_taken: got %b/%h expected 1/00c", branch_taken, branch_target);
    end
    flush = 1;
    #1;
    checks++;
    if (branch_taken !== 1'b0) begin
      errors++; $display("FAIL beq_flushed: got %b expected 0", branch_taken);
    end
    flush = 0; ex_read_data2 = 16'h0006;
    #1;
    checks++;
    if (branch_taken !== 1'b0) begin
      errors++; $display("FAIL beq_not_equal: got %b expected 0", branch_taken);
    end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_random_single_cycle();
    logic [37:0] exp;
    bit allow_op3;
`ifdef EX_MUL_EN
    allow_op3 = 0;
`else
    allow_op3 = 1;
`endif
    for (int i = 0; i < 300; i++) begin
      rand_inputs(allow_op3);
      #1;
      checks++;
      if (branch_taken !== exp_taken() || branch_target !== exp_target()) begin
        errors++;
        $display("FAIL rand_branch[%0d]: got %b/%h expected %b/%h", i, branch_taken, branch_target,
                 exp_taken(), exp_target());
      end
      exp = exp_exmem();
      @(posedge clk); #1;
      checks++;
      if (exmem_obs !== exp) begin
        errors++; $display("FAIL rand_exmem[%0d]: got %h expected %h", i, exmem_obs, exp);
      end
    end
    clear_inputs();
  endtask

`ifdef EX_MUL_EN
  // Starts a MUL at the current cycle and follows it to its EX/MEM write.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input string name);
    int n;
    logic [37:0] exp;
    clear_inputs();
    ex_alu_op = 2'd3; ex_reg_write = 1; ex_rd = 3'($urandom_range(1, 7));
    ex_read_data1 = a; ex_read_data2 = b; ex_branch = 1;
    exp = {1'b1, 2'b00, ex_rd, b, 16'((longint'(a) * longint'(b)) % 65536)};
    #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      checks++;
      if (branch_taken !== 1'b0) begin
        errors++; $display("FAIL %s_branch_in_stall: got %b expected 0", name, branch_taken);
      end
      n++;
      @(posedge clk); #1;
      checks++;
      if (exmem_obs !== 38'd0) begin
        errors++; $display("FAIL %s_bubble: got %h expected 0", name, exmem_obs);
      end
    end
    checks++;
    if (n != 17) begin
      errors++; $display("FAIL %s_stall_cycles: got %0d expected 17", name, n);
    end
    @(posedge clk); #1;
    checks++;
    if (exmem_obs !== exp) begin
      errors++; $display("FAIL %s_result: got %h expected %h", name, exmem_obs, exp);
    end
  endtask

  task automatic test_mul();
    run_mul(16'h0003, 16'h0007, "mul_3x7");
    clear_inputs(); @(posedge clk); #1;
    run_mul(16'h0100, 16'h0100, "mul_wrap");
    clear_inputs(); @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      run_mul(16'($urandom), 16'($urandom), "mul_rand");
      clear_inputs(); @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    run_mul(16'h1234, 16'h0011, "b2b_first");
    run_mul(16'hFFFF, 16'hFFFF, "b2b_second");
    clear_inputs(); @(posedge clk); #1;
  endtask

  task automatic test_flush_busy();
    clear_inputs();
    ex_alu_op = 2'd3; ex_reg_write = 1; ex_rd = 3'd1;
    ex_read_data1 = 16'h0009; ex_read_data2 = 16'h0009;
    repeat (4) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk); #1;
    checks++;
    if (exmem_obs !== 38'd0) begin
      errors++; $display("FAIL flush_busy_bubble: got %h expected 0", exmem_obs);
    end
    flush = 0; ex_alu_op = 2'd0; ex_read_data1 = 16'h0100; ex_read_data2 = 16'h0023;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_busy_idle: got stall %b expected 0", stall);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_alu_result !== 16'h0123) begin
      errors++; $display("FAIL flush_busy_next_add: got %h expected 0123", mem_alu_result);
    end
    run_mul(16'h0005, 16'h0006, "mul_after_flush");
    clear_inputs(); @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    clear_inputs();
    ex_alu_op = 2'd3; ex_reg_write = 1; ex_rd = 3'd6;
    ex_read_data1 = 16'h0033; ex_read_data2 = 16'h0044;
    repeat (6) @(posedge clk);
    #1;
    reset = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || exmem_obs !== 38'd0) begin
      errors++; $display("FAIL reset_mid_mul: got stall %b exmem %h expected 0/0", stall, exmem_obs);
    end
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0 || exmem_obs !== 38'd0) begin
      errors++; $display("FAIL reset_mid_mul_held: got stall %b exmem %h expected 0/0", stall, exmem_obs);
    end
    reset = 0;
    run_mul(16'h0002, 16'h0002, "mul_after_reset");
    clear_inputs(); @(posedge clk); #1;
  endtask
`endif

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_alu_directed();
    test_forwarding();
    test_branch();
    test_random_single_cycle();
`ifdef EX_MUL_EN
    test_mul();
    test_back_to_back();
    test_flush_busy();
    test_reset_mid_mul();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
